cpu_multicycle: RTL and testbench

Parametrised multi-cycle successor to the first single-path CPU. Holds a loadable instruction memory, a register file and an ALU behind one explicit FETCH/DECODE/EXECUTE/WRITEBACK state machine. Adds start/halt control, immediate loads, an extended opcode set and a host load port. Sits at the top of the CPU hierarchy; the host loads a program, pulses `start` and observes progress via the status outputs.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/cpu_multicycle_if.sv | 40 ++++
 rtl/cpu_alu.sv | 36 +++
 rtl/cpu_multicycle.sv | 152 +++++++++++++++
 tb/tb_cpu_multicycle.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle CPU slice:
//   - opcode constants OP_ADD .. OP_HALT
//   - control state enumeration state_t
//   - instWidth(): instruction word width derived from the register address width
//   - field-slice helpers for pulling op / register / immediate fields out of
//     an instruction word. The word is passed zero-extended to 32 bits so the
//     helpers can serve any parameterisation.
// Instruction layout, MSB first: op[2:0], dest, src1, src2 (each REG_AW bits).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Register-field slot positions, counted from the LSB end of the word
    localparam int SLOT_SRC2 = 0;
    localparam int SLOT_SRC1 = 1;
    localparam int SLOT_DEST = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    function automatic int instWidth(input int regAw);
        return 3 + 3 * regAw;
    endfunction

    function automatic logic [2:0] fieldOp(input logic [31:0] inst, input int regAw);
        return 3'((inst >> (3 * regAw)) & 32'h7);
    endfunction

    function automatic logic [7:0] fieldReg(input logic [31:0] inst, input int regAw,
                                            input int slot);
        logic [31:0] mask;
        mask = (32'd1 << regAw) - 32'd1;
        return 8'((inst >> (slot * regAw)) & mask);
    endfunction

    // The immediate of LDI is simply the concatenation {src1, src2}
    function automatic logic [15:0] fieldImm(input logic [31:0] inst, input int regAw);
        logic [31:0] mask;
        mask = (32'd1 << (2 * regAw)) - 32'd1;
        return 16'(inst & mask);
    endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// ---------------------------------------------------------------------------
// cpu_multicycle_if
// Host-side bundle of the CPU.
//   master (host) drives : start, imem_we, imem_waddr, imem_wdata
//   slave  (CPU)  drives : busy, halted, pc_out, inst_out, result_out,
//                          result_valid
// ---------------------------------------------------------------------------
interface cpu_multicycle_if
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 2,
    parameter int IMEM_AW = 4
) ();

    localparam int INST_W = instWidth(REG_AW);

    logic               start;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [INST_W-1:0]  imem_wdata;

    logic               busy;
    logic               halted;
    logic [IMEM_AW-1:0] pc_out;
    logic [INST_W-1:0]  inst_out;
    logic [DATA_W-1:0]  result_out;
    logic               result_valid;

    modport master (
        output start, imem_we, imem_waddr, imem_wdata,
        input  busy, halted, pc_out, inst_out, result_out, result_valid
    );

    modport slave (
        input  start, imem_we, imem_waddr, imem_wdata,
        output busy, halted, pc_out, inst_out, result_out, result_valid
    );

endinterface

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu
// Purely combinational ALU, all arithmetic modulo 2^DATA_W.
//   op_i     : opcode
//   a_i, b_i : operands latched from the register file
//   imm_i    : 2*REG_AW-bit immediate used by LDI
//   result_o : result; zero for HALT
// ---------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic [2:0]          op_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [2*REG_AW-1:0] imm_i,
    output logic [DATA_W-1:0]   result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_LDI:  result_o = DATA_W'(imm_i);
            OP_MOV:  result_o = a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle.sv
// ---------------------------------------------------------------------------
// cpu_multicycle
// Multi-cycle CPU: loadable instruction memory, register file and ALU driven
// by a FETCH/DECODE/EXECUTE/WRITEBACK state machine.
//   clk   : single clock, rising edge
//   reset : asynchronous active-high; clears everything except imem contents
//   host  : cpu_multicycle_if.slave (start, imem load port, status outputs)
// ---------------------------------------------------------------------------
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_AW  = 2,
    parameter int IMEM_AW = 4
) (
    input  logic            clk,
    input  logic            reset,
    cpu_multicycle_if.slave host
);

    localparam int INST_W     = instWidth(REG_AW);
    localparam int IMM_W      = 2 * REG_AW;
    localparam int NUM_REGS   = 1 << REG_AW;
    localparam int IMEM_DEPTH = 1 << IMEM_AW;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0]  opA_q, opA_d;
    logic [DATA_W-1:0]  opB_q, opB_d;

    logic [INST_W-1:0]  imem [IMEM_DEPTH];
    logic [DATA_W-1:0]  rf_q [NUM_REGS];

    logic [31:0]        instWide;
    logic [2:0]         instOp;
    logic [REG_AW-1:0]  instDest;
    logic [REG_AW-1:0]  instSrc1;
    logic [REG_AW-1:0]  instSrc2;
    logic [IMM_W-1:0]   instImm;
    logic [DATA_W-1:0]  aluResult;
    logic               busy;

    assign instWide = 32'(inst_q);
    assign instOp   = fieldOp(instWide, REG_AW);
    assign instDest = REG_AW'(fieldReg(instWide, REG_AW, SLOT_DEST));
    assign instSrc1 = REG_AW'(fieldReg(instWide, REG_AW, SLOT_SRC1));
    assign instSrc2 = REG_AW'(fieldReg(instWide, REG_AW, SLOT_SRC2));
    assign instImm  = IMM_W'(fieldImm(instWide, REG_AW));

    assign busy = (state_q == S_FETCH)   || (state_q == S_DECODE) ||
                  (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

    cpu_alu #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_alu (
        .op_i     (instOp),
        .a_i      (opA_q),
        .b_i      (opB_q),
        .imm_i    (instImm),
        .result_o (aluResult)
    );

    // Next-state and datapath-update logic. Operands are captured in DECODE,
    // so a WRITEBACK to the same register can never race with the read.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        result_d = result_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (host.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                inst_d  = imem[pc_q];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (instOp == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    opA_d   = rf_q[instSrc1];
                    opB_d   = rf_q[instSrc2];
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                result_d = aluResult;
                state_d  = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + IMEM_AW'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            inst_q   <= '0;
            result_q <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            result_q <= result_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
        end
    end

    // Register file commits at the edge that ends WRITEBACK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (state_q == S_WRITEBACK) begin
            rf_q[instDest] <= result_q;
        end
    end

    // Instruction memory has no reset so a loaded program survives one;
    // host writes are locked out while a program is running.
    always_ff @(posedge clk) begin
        if (host.imem_we && !busy) begin
            imem[host.imem_waddr] <= host.imem_wdata;
        end
    end

    assign host.busy         = busy;
    assign host.halted       = (state_q == S_HALTED);
    assign host.result_valid = (state_q == S_WRITEBACK);
    assign host.pc_out       = pc_q;
    assign host.inst_out     = inst_q;
    assign host.result_out   = result_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_cpu_multicycle
// Directed programs with hand-computed results. Expected result_out values
// are queued before each run; a negedge monitor pops one per result_valid.
// ---------------------------------------------------------------------------
module tb_cpu_multicycle;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] expQ[$];

    cpu_multicycle_if #(.DATA_W(8), .REG_AW(2), .IMEM_AW(4)) hostIf ();

    cpu_multicycle #(
        .DATA_W  (8),
        .REG_AW  (2),
        .IMEM_AW (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .host  (hostIf)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [1:0] d,
                                       input logic [1:0] s1, input logic [1:0] s2);
        return {op, d, s1, s2};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic loadWord(input logic [3:0] addr, input logic [8:0] data);
        hostIf.imem_we    = 1'b1;
        hostIf.imem_waddr = addr;
        hostIf.imem_wdata = data;
        @(posedge clk); #1;
        hostIf.imem_we    = 1'b0;
    endtask

    // Pulses start and counts cycles until halted (bounded). With interfere
    // set, a start pulse and an imem write to address 2 are issued mid-run.
    task automatic applyStimulus(input bit interfere, output int cycles);
        hostIf.start = 1'b1;
        @(posedge clk); #1;
        hostIf.start = 1'b0;
        cycles = 0;
        while (hostIf.halted !== 1'b1 && cycles < 40) begin
            if (interfere && cycles == 2) begin
                hostIf.start      = 1'b1;
                hostIf.imem_we    = 1'b1;
                hostIf.imem_waddr = 4'd2;
                hostIf.imem_wdata = enc(OP_LDI, 2'd0, 2'd3, 2'd3);
            end
            @(posedge clk); #1;
            hostIf.start   = 1'b0;
            hostIf.imem_we = 1'b0;
            cycles++;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"},   32'(hostIf.busy),         32'd0);
        checkOutput({tag, "_halted"}, 32'(hostIf.halted),       32'd0);
        checkOutput({tag, "_valid"},  32'(hostIf.result_valid), 32'd0);
        checkOutput({tag, "_pc"},     32'(hostIf.pc_out),       32'd0);
        checkOutput({tag, "_inst"},   32'(hostIf.inst_out),     32'd0);
        checkOutput({tag, "_result"}, 32'(hostIf.result_out),   32'd0);
    endtask

    task automatic checkHalt(input string tag, input int cycles);
        checkOutput({tag, "_latency"}, 32'(cycles),          32'd14);
        checkOutput({tag, "_halted"},  32'(hostIf.halted),   32'd1);
        checkOutput({tag, "_pc"},      32'(hostIf.pc_out),   32'd3);
        checkOutput({tag, "_inst"},    32'(hostIf.inst_out), 32'h1C0);
    endtask

    // Scoreboard monitor: each result_valid pulse consumes one expectation
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (hostIf.result_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result",
                             hostIf.result_out);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("result", 32'(hostIf.result_out), 32'(exp));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int busyDrops;
        logic [3:0] pcAt60;
        logic [3:0] pcAt64;

        reset              = 1'b1;
        hostIf.start       = 1'b0;
        hostIf.imem_we     = 1'b0;
        hostIf.imem_waddr  = '0;
        hostIf.imem_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        reset = 1'b0;

        // Program A: LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT
        loadWord(4'd0, enc(OP_LDI,  2'd1, 2'd1, 2'd1));
        loadWord(4'd1, enc(OP_LDI,  2'd2, 2'd0, 2'd3));
        loadWord(4'd2, enc(OP_ADD,  2'd3, 2'd1, 2'd2));
        loadWord(4'd3, enc(OP_HALT, 2'd0, 2'd0, 2'd0));
        expQ.push_back(8'd5);
        expQ.push_back(8'd3);
        expQ.push_back(8'd8);
        applyStimulus(1'b0, cycles);
        checkHalt("progA", cycles);

        // Program B from HALTED, registers retained:
        // SUB r0,r2,r1 = 3-5 wraps; XOR r1,r1,r1 = 0; MOV r0,r3 = 8 (r3 from A).
        // Mid-run start and imem write to address 2 must both be ignored.
        loadWord(4'd0, enc(OP_SUB, 2'd0, 2'd2, 2'd1));
        loadWord(4'd1, enc(OP_XOR, 2'd1, 2'd1, 2'd1));
        loadWord(4'd2, enc(OP_MOV, 2'd0, 2'd3, 2'd0));
        expQ.push_back(8'hFE);
        expQ.push_back(8'h00);
        expQ.push_back(8'h08);
        applyStimulus(1'b1, cycles);
        checkHalt("progB", cycles);

        // Reset during EXECUTE of ADD r3: program A again
        loadWord(4'd0, enc(OP_LDI, 2'd1, 2'd1, 2'd1));
        loadWord(4'd1, enc(OP_LDI, 2'd2, 2'd0, 2'd3));
        loadWord(4'd2, enc(OP_ADD, 2'd3, 2'd1, 2'd2));
        expQ.push_back(8'd5);
        expQ.push_back(8'd3);
        hostIf.start = 1'b1;
        @(posedge clk); #1;
        hostIf.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_pcBefore",   32'(hostIf.pc_out), 32'd2);
        checkOutput("abort_busyBefore", 32'(hostIf.busy),   32'd1);
        reset = 1'b1;
        #1;
        checkResetState("abort");
        @(posedge clk); #1;
        reset = 1'b0;

        // Word 0 becomes MOV r0,r3 to expose r3 (cleared); words 1..3 must be
        // intact: LDI r2,3 then ADD r3 = r1(0) + r2(3).
        loadWord(4'd0, enc(OP_MOV, 2'd0, 2'd3, 2'd0));
        expQ.push_back(8'd0);
        expQ.push_back(8'd3);
        expQ.push_back(8'd3);
        applyStimulus(1'b0, cycles);
        checkHalt("postAbort", cycles);

        // Restoring word 0 reproduces the original program A results
        loadWord(4'd0, enc(OP_LDI, 2'd1, 2'd1, 2'd1));
        expQ.push_back(8'd5);
        expQ.push_back(8'd3);
        expQ.push_back(8'd8);
        applyStimulus(1'b0, cycles);
        checkHalt("rerunA", cycles);

        // No HALT anywhere: MOV r0,r1 (r1=5) everywhere, PC wraps 15 -> 0
        for (int a = 0; a < 16; a++) begin
            loadWord(4'(a), enc(OP_MOV, 2'd0, 2'd1, 2'd0));
        end
        for (int i = 0; i < 18; i++) begin
            expQ.push_back(8'd5);
        end
        busyDrops = 0;
        pcAt60    = '0;
        pcAt64    = '1;
        hostIf.start = 1'b1;
        @(posedge clk); #1;
        hostIf.start = 1'b0;
        for (int n = 1; n <= 72; n++) begin
            @(posedge clk); #1;
            if (hostIf.busy !== 1'b1) busyDrops++;
            if (n == 60) pcAt60 = hostIf.pc_out;
            if (n == 64) pcAt64 = hostIf.pc_out;
        end
        checkOutput("wrap_pc15",      32'(pcAt60),        32'd15);
        checkOutput("wrap_pc0",       32'(pcAt64),        32'd0);
        checkOutput("wrap_busyDrops", 32'(busyDrops),     32'd0);
        checkOutput("wrap_halted",    32'(hostIf.halted), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
